// File: rtl/risc16_sequencer.sv
// rtl/risc16_sequencer.sv - RiSC-16 instruction sequencer: fetch handshake, two-phase execute, halt detection
module risc16_sequencer #(
  parameter int OP_LEN  = 3,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               i_req,
  input  logic               i_ack,
  input  logic [INSTR_W-1:0] i_data,
  input  logic               d_busy,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_LEN-1:0]  op,
  output logic               state,
  output logic               pen,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC0 = 3'd2,
    EXEC1 = 3'd3,
    HALT  = 3'd4
  } seqState_t;

  localparam logic [OP_LEN-1:0] OP_SW   = OP_LEN'(3'b100);
  localparam logic [OP_LEN-1:0] OP_LW   = OP_LEN'(3'b101);
  localparam logic [OP_LEN-1:0] OP_JALR = OP_LEN'(3'b111);

  seqState_t curState;
  logic      isMem;
  logic      isHalt;
  logic      memStall;

  assign op       = instr[INSTR_W-1 -: OP_LEN];
  assign isMem    = (op == OP_SW) || (op == OP_LW);
  assign isHalt   = (op == OP_JALR) && (instr[6:0] != 7'd0);
  assign memStall = isMem && d_busy;

  // Commit strobe is Mealy on d_busy so a memory op retires in the cycle the memory frees up.
  assign pen = (curState == EXEC1) && !memStall && !isHalt;

  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= IDLE;
      i_req    <= 1'b0;
      instr    <= '0;
      state    <= 1'b0;
      halted   <= 1'b0;
      retired  <= '0;
    end else begin
      case (curState)
        IDLE: begin
          if (run) begin
            curState <= FETCH;
            i_req    <= 1'b1;
          end
        end
        FETCH: begin
          if (i_ack) begin
            instr    <= i_data;
            i_req    <= 1'b0;
            curState <= EXEC0;
          end
        end
        EXEC0: begin
          state    <= 1'b1;
          curState <= EXEC1;
        end
        EXEC1: begin
          if (!memStall) begin
            retired <= retired + CNT_W'(1);
            state   <= 1'b0;
            if (isHalt) begin
              halted   <= 1'b1;
              curState <= HALT;
            end else begin
              i_req    <= 1'b1;
              curState <= FETCH;
            end
          end
        end
        HALT: begin
          // instr and op stay visible so the halting instruction can be inspected.
          if (run) begin
            halted   <= 1'b0;
            i_req    <= 1'b1;
            curState <= FETCH;
          end
        end
        default: begin
          curState <= IDLE;
          i_req    <= 1'b0;
          state    <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc16_sequencer.sv
// tb/tb_risc16_sequencer.sv - self-checking bench for risc16_sequencer
module tb_risc16_sequencer;
  localparam int OP_LEN  = 3;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               i_req;
  logic               i_ack;
  logic [INSTR_W-1:0] i_data;
  logic               d_busy;
  logic [INSTR_W-1:0] instr;
  logic [OP_LEN-1:0]  op;
  logic               state;
  logic               pen;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  int checks = 0;
  int errors = 0;
  int expRetired = 0;
  logic [15:0] expInstr = 16'h0000;

  risc16_sequencer #(.OP_LEN(OP_LEN), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .i_req(i_req), .i_ack(i_ack), .i_data(i_data),
    .d_busy(d_busy), .instr(instr), .op(op), .state(state), .pen(pen),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic isHaltWord(input logic [15:0] w);
    return (w[15:13] == 3'b111) && (w[6:0] != 7'd0);
  endfunction

  function automatic logic isMemWord(input logic [15:0] w);
    return (w[15:13] == 3'b100) || (w[15:13] == 3'b101);
  endfunction

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; i_ack = 1'b0; i_data = 16'h0000; d_busy = 1'b0;
    nextCycle(); nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({i_req, state, pen, halted} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {i_req, state, pen, halted}); end
    checks++; if (instr !== 16'h0000 || op !== 3'b000)
      begin errors++; $display("FAIL reset_instr got %h/%0d want 0000/0", instr, op); end
    checks++; if (retired !== 4'd0)
      begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    // idle with run low: stays idle, stray ack ignored
    i_ack = 1'b1; i_data = 16'hFFFF;
    nextCycle(); nextCycle();
    i_ack = 1'b0;
    @(negedge clk);
    checks++; if (i_req !== 1'b0 || instr !== 16'h0000)
      begin errors++; $display("FAIL idle_hold got req=%b instr=%h want 0/0000", i_req, instr); end
    nextCycle();
  endtask

  task automatic start_run();
    run = 1'b1;
    nextCycle();
    run = 1'b0;
  endtask

  // Walks one instruction from the first FETCH cycle to the cycle after it retires.
  task automatic do_instr(input logic [15:0] data, input int ackDelay, input int busyN,
                          input logic busyNonMem);
    logic mem;
    logic hlt;
    int   stalls;
    logic expPen;
    mem = isMemWord(data);
    hlt = isHaltWord(data);
    stalls = mem ? busyN : 0;
    for (int c = 0; c <= ackDelay; c++) begin
      i_ack = (c == ackDelay);
      i_data = (c == ackDelay) ? data : 16'($urandom);
      d_busy = 1'($urandom); run = 1'($urandom);
      @(negedge clk);
      checks++; if (i_req !== 1'b1)
        begin errors++; $display("FAIL fetch_req cyc %0d got %b want 1", c, i_req); end
      checks++; if ({state, pen, halted} !== 3'b000)
        begin errors++; $display("FAIL fetch_flags got %b want 000", {state, pen, halted}); end
      checks++; if (instr !== expInstr)
        begin errors++; $display("FAIL fetch_instr got %h want %h", instr, expInstr); end
      nextCycle();
    end
    expInstr = data;
    i_ack = 1'($urandom); i_data = 16'($urandom); d_busy = 1'($urandom); run = 1'($urandom);
    @(negedge clk);
    checks++; if ({i_req, state, pen} !== 3'b000)
      begin errors++; $display("FAIL exec0_flags got %b want 000", {i_req, state, pen}); end
    checks++; if (instr !== data || op !== data[15:13])
      begin errors++; $display("FAIL exec0_instr got %h/%0d want %h/%0d", instr, op, data, data[15:13]); end
    nextCycle();
    for (int k = 0; k <= stalls; k++) begin
      d_busy = mem ? (k < busyN) : busyNonMem;
      i_ack = 1'($urandom); i_data = 16'($urandom); run = 1'($urandom);
      expPen = (k == stalls) && !hlt;
      @(negedge clk);
      checks++; if (state !== 1'b1 || i_req !== 1'b0)
        begin errors++; $display("FAIL exec1_state cyc %0d got st=%b req=%b want 1/0", k, state, i_req); end
      checks++; if (pen !== expPen)
        begin errors++; $display("FAIL exec1_pen cyc %0d got %b want %b", k, pen, expPen); end
      checks++; if (retired !== CNT_W'(expRetired))
        begin errors++; $display("FAIL exec1_retired got %0d want %0d", retired, expRetired); end
      nextCycle();
    end
    expRetired = (expRetired + 1) % (1 << CNT_W);
    run = 1'b0; i_ack = 1'b0; d_busy = 1'b0;
    checks++; if (retired !== CNT_W'(expRetired))
      begin errors++; $display("FAIL retire_count got %0d want %0d", retired, expRetired); end
    checks++; if ({halted, i_req, pen, state} !== {hlt, !hlt, 1'b0, 1'b0})
      begin errors++; $display("FAIL after_retire got %b want %b", {halted, i_req, pen, state}, {hlt, !hlt, 2'b00}); end
  endtask

  task automatic resume_halt();
    for (int c = 0; c < 3; c++) begin
      i_ack = 1'($urandom); i_data = 16'($urandom); d_busy = 1'($urandom);
      @(negedge clk);
      checks++; if ({halted, i_req, pen} !== 3'b100)
        begin errors++; $display("FAIL halt_hold got %b want 100", {halted, i_req, pen}); end
      checks++; if (instr !== expInstr || op !== expInstr[15:13])
        begin errors++; $display("FAIL halt_instr got %h want %h", instr, expInstr); end
      nextCycle();
    end
    i_ack = 1'b0;
    start_run();
    checks++; if ({halted, i_req} !== 2'b01)
      begin errors++; $display("FAIL halt_resume got %b want 01", {halted, i_req}); end
  endtask

  task automatic test_basic();
    start_run();
    do_instr(16'h0000, 0, 0, 1'b0);   // ADD, immediate ack
    do_instr(16'hA000, 3, 2, 1'b0);   // LW, late ack, 2 busy cycles
    do_instr(16'h2001, 0, 3, 1'b1);   // ADDI ignores d_busy
    do_instr(16'h8000 | 16'($urandom_range(0, 16'h1FFF)), 1, 1, 1'b0);
    do_instr(16'hE000, 0, 0, 1'b0);   // JALR with zero imm is not a halt
  endtask

  task automatic test_halt();
    do_instr(16'hE001, 2, 0, 1'b1);
    resume_halt();
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if (isHaltWord(w)) resume_halt();
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 20 && expRetired != (1 << CNT_W) - 1; n++)
      do_instr(16'h0000, 0, 0, 1'b0);
    checks++; if (retired !== {CNT_W{1'b1}})
      begin errors++; $display("FAIL wrap_pre got %0d want %0d", retired, (1 << CNT_W) - 1); end
    do_instr(16'h6000, 0, 0, 1'b0);
    checks++; if (retired !== '0)
      begin errors++; $display("FAIL wrap_zero got %0d want 0", retired); end
  endtask

  task automatic test_reset_in_fetch();
    i_ack = 1'b1; i_data = 16'h1234; rst = 1'b1;
    nextCycle();
    rst = 1'b0; i_ack = 1'b0;
    expRetired = 0; expInstr = 16'h0000;
    checks++; if (instr !== 16'h0000 || i_req !== 1'b0)
      begin errors++; $display("FAIL rst_fetch got instr=%h req=%b want 0000/0", instr, i_req); end
    checks++; if (retired !== '0 || halted !== 1'b0)
      begin errors++; $display("FAIL rst_fetch_cnt got %0d/%b want 0/0", retired, halted); end
    nextCycle();
    checks++; if (i_req !== 1'b0)
      begin errors++; $display("FAIL rst_idle got req=%b want 0", i_req); end
    start_run();
    do_instr(16'h4321, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_random();
    test_wrap();
    test_reset_in_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
